// File: rtl/sched_pkg.sv
// Shared types, default widths and the width helper for the task scheduler.
package sched_pkg;

  localparam int DEF_NUM_CORES = 4;
  localparam int DEF_NUM_PRIO  = 4;
  localparam int DEF_Q_DEPTH   = 16;
  localparam int DEF_DUR_W     = 8;
  localparam int DEF_TAG_W     = 8;

  // One queued task at the default widths: duration in the upper field, tag in the lower.
  typedef struct packed {
    logic [DEF_DUR_W-1:0] dur;
    logic [DEF_TAG_W-1:0] tag;
  } task_entry_t;

  // Bits needed to index n items; never less than 1 so single-item selects stay legal.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/prio_fifo.sv
// Synchronous FIFO for one priority level; full/empty come from an extra wrap bit on the pointers.
module prio_fifo
  import sched_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = clog2(DEPTH);

  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];

  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  // Advance pointers on guarded push/pop; both may move in the same cycle.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_i && !full_o) wr_d = wr_q + (AW+1)'(1);
    if (pop_i && !empty_o) rd_d = rd_q + (AW+1)'(1);
  end

  // Pointer registers; clearing both empties the FIFO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage write; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/multicore_task_scheduler.sv
// Priority task scheduler: per-level FIFOs feed one dispatch per cycle to the
// lowest-indexed free enabled core, which then counts its task down to completion.
module multicore_task_scheduler
  import sched_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int NUM_PRIO  = 4,
  parameter int Q_DEPTH   = 16,
  parameter int DUR_W     = 8,
  parameter int TAG_W     = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          task_valid,
  output logic                          task_ready,
  input  logic [clog2(NUM_PRIO)-1:0]    task_prio,
  input  logic [DUR_W-1:0]              task_dur,
  output logic [TAG_W-1:0]              task_tag,
  input  logic [NUM_CORES-1:0]          core_enable,
  output logic [NUM_CORES-1:0]          core_busy,
  output logic [NUM_CORES*DUR_W-1:0]    core_remaining,
  output logic [NUM_CORES-1:0]          core_done,
  output logic [NUM_CORES*TAG_W-1:0]    core_tag,
  output logic                          disp_valid,
  output logic [clog2(NUM_CORES)-1:0]   disp_core,
  output logic [clog2(NUM_PRIO)-1:0]    disp_prio,
  output logic [NUM_PRIO-1:0]           q_empty
);

  localparam int PW = clog2(NUM_PRIO);
  localparam int CW = clog2(NUM_CORES);
  localparam int EW = DUR_W + TAG_W;

  logic [NUM_PRIO-1:0]  push, pop, full, empty;
  logic [EW-1:0]        head [NUM_PRIO];
  logic [DUR_W-1:0]     dur_eff;
  logic                 accept;

  logic [TAG_W-1:0]     tag_q, tag_d;
  logic                 disp_valid_q, disp_valid_d;
  logic [CW-1:0]        disp_core_q, disp_core_d;
  logic [PW-1:0]        disp_prio_q, disp_prio_d;

  logic [NUM_CORES-1:0] busy_q, busy_d;
  logic [NUM_CORES-1:0] done_q, done_d;
  logic [DUR_W-1:0]     rem_q  [NUM_CORES];
  logic [DUR_W-1:0]     rem_d  [NUM_CORES];
  logic [TAG_W-1:0]     ctag_q [NUM_CORES];
  logic [TAG_W-1:0]     ctag_d [NUM_CORES];

  logic [NUM_CORES-1:0] free;
  logic                 lvl_any, core_any, do_disp;
  logic [PW-1:0]        lvl_sel;
  logic [CW-1:0]        core_sel;
  logic [EW-1:0]        head_sel;

  // A zero duration still occupies a core for one cycle.
  assign dur_eff = (task_dur == '0) ? DUR_W'(1) : task_dur;
  assign accept  = task_valid && task_ready;

  // Ready reflects the pre-pop fullness of the addressed level only.
  always_comb begin
    task_ready = 1'b0;
    for (int p = 0; p < NUM_PRIO; p++) begin
      if (task_prio == PW'(p)) task_ready = !full[p];
    end
  end

  // Steer an accepted task to its level's FIFO.
  always_comb begin
    for (int p = 0; p < NUM_PRIO; p++) push[p] = accept && (task_prio == PW'(p));
  end

  for (genvar p = 0; p < NUM_PRIO; p++) begin : g_fifo
    prio_fifo #(
      .W     (EW),
      .DEPTH (Q_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (push[p]),
      .pop_i   (pop[p]),
      .din_i   ({dur_eff, tag_q}),
      .dout_o  (head[p]),
      .full_o  (full[p]),
      .empty_o (empty[p])
    );
  end

  // Priority encoder: the highest non-empty level wins (later iterations override).
  always_comb begin
    lvl_any  = 1'b0;
    lvl_sel  = '0;
    head_sel = '0;
    for (int p = 0; p < NUM_PRIO; p++) begin
      if (!empty[p]) begin
        lvl_any  = 1'b1;
        lvl_sel  = PW'(p);
        head_sel = head[p];
      end
    end
  end

  assign free = ~busy_q & core_enable;

  // Lowest-indexed free core finder (scan downward so the lowest index lands last).
  always_comb begin
    core_any = 1'b0;
    core_sel = '0;
    for (int c = NUM_CORES - 1; c >= 0; c--) begin
      if (free[c]) begin
        core_any = 1'b1;
        core_sel = CW'(c);
      end
    end
  end

  assign do_disp = lvl_any && core_any;

  // Pop exactly the level being dispatched.
  always_comb begin
    for (int p = 0; p < NUM_PRIO; p++) pop[p] = do_disp && (lvl_sel == PW'(p));
  end

  // Tag counter and dispatch report next state.
  always_comb begin
    tag_d        = accept ? tag_q + TAG_W'(1) : tag_q;
    disp_valid_d = do_disp;
    disp_core_d  = do_disp ? core_sel : disp_core_q;
    disp_prio_d  = do_disp ? lvl_sel  : disp_prio_q;
  end

  // Per-core execution: load on dispatch, count down while busy, pulse done on 1->0.
  always_comb begin
    busy_d = busy_q;
    done_d = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      rem_d[c]  = rem_q[c];
      ctag_d[c] = ctag_q[c];
      if (do_disp && (core_sel == CW'(c))) begin
        busy_d[c] = 1'b1;
        rem_d[c]  = head_sel[EW-1 -: DUR_W];
        ctag_d[c] = head_sel[TAG_W-1:0];
      end else if (busy_q[c]) begin
        if (rem_q[c] == DUR_W'(1)) begin
          busy_d[c] = 1'b0;
          rem_d[c]  = '0;
          done_d[c] = 1'b1;
        end else begin
          rem_d[c] = rem_q[c] - DUR_W'(1);
        end
      end
    end
  end

  // State registers; reset discards running work without a completion pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_q        <= '0;
      disp_valid_q <= 1'b0;
      disp_core_q  <= '0;
      disp_prio_q  <= '0;
      busy_q       <= '0;
      done_q       <= '0;
      for (int c = 0; c < NUM_CORES; c++) begin
        rem_q[c]  <= '0;
        ctag_q[c] <= '0;
      end
    end else begin
      tag_q        <= tag_d;
      disp_valid_q <= disp_valid_d;
      disp_core_q  <= disp_core_d;
      disp_prio_q  <= disp_prio_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      for (int c = 0; c < NUM_CORES; c++) begin
        rem_q[c]  <= rem_d[c];
        ctag_q[c] <= ctag_d[c];
      end
    end
  end

  for (genvar c = 0; c < NUM_CORES; c++) begin : g_core_out
    assign core_remaining[c*DUR_W +: DUR_W] = rem_q[c];
    assign core_tag[c*TAG_W +: TAG_W]       = ctag_q[c];
  end

  assign task_tag   = tag_q;
  assign core_busy  = busy_q;
  assign core_done  = done_q;
  assign disp_valid = disp_valid_q;
  assign disp_core  = disp_core_q;
  assign disp_prio  = disp_prio_q;
  assign q_empty    = empty;

endmodule

// File: tb/tb_multicore_task_scheduler.sv
// Directed bench for the multicore task scheduler at default parameters.
module tb_multicore_task_scheduler;

  logic        clk;
  logic        reset_n;
  logic        task_valid;
  logic        task_ready;
  logic [1:0]  task_prio;
  logic [7:0]  task_dur;
  logic [7:0]  task_tag;
  logic [3:0]  core_enable;
  logic [3:0]  core_busy;
  logic [31:0] core_remaining;
  logic [3:0]  core_done;
  logic [31:0] core_tag;
  logic        disp_valid;
  logic [1:0]  disp_core;
  logic [1:0]  disp_prio;
  logic [3:0]  q_empty;

  int n_cmp = 0;
  int n_err = 0;

  multicore_task_scheduler dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .task_valid     (task_valid),
    .task_ready     (task_ready),
    .task_prio      (task_prio),
    .task_dur       (task_dur),
    .task_tag       (task_tag),
    .core_enable    (core_enable),
    .core_busy      (core_busy),
    .core_remaining (core_remaining),
    .core_done      (core_done),
    .core_tag       (core_tag),
    .disp_valid     (disp_valid),
    .disp_core      (disp_core),
    .disp_prio      (disp_prio),
    .q_empty        (q_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!(q_empty == 4'hF && core_busy == 4'h0) && n < 400) begin
      step();
      n++;
    end
    check(tag, {q_empty, core_busy}, {4'hF, 4'h0});
  endtask

  initial begin
    reset_n     = 1'b0;
    task_valid  = 1'b0;
    task_prio   = 2'd0;
    task_dur    = 8'd0;
    core_enable = 4'h0;

    // ---- reset state ----
    step(); step();
    check("rst_busy",   core_busy, 4'h0);
    check("rst_done",   core_done, 4'h0);
    check("rst_rem",    core_remaining, 32'h0);
    check("rst_ctag",   core_tag, 32'h0);
    check("rst_disp",   {disp_valid, disp_core, disp_prio}, 5'h0);
    check("rst_qempty", q_empty, 4'hF);
    check("rst_tag",    task_tag, 8'h0);
    check("rst_ready",  task_ready, 1'b1);
    reset_n = 1'b1;

    // ---- single task p2 dur5, tag 0 ----
    core_enable = 4'hF;
    task_valid = 1'b1; task_prio = 2'd2; task_dur = 8'd5;
    step();                                    // edge k: accepted
    task_valid = 1'b0;
    check("single_qempty_k", q_empty, 4'b1011);
    check("single_busy_k",   core_busy, 4'h0);
    check("single_tag_k",    task_tag, 8'd1);
    step();                                    // edge k+1: dispatched
    check("single_disp", {disp_valid, disp_core, disp_prio}, {1'b1, 2'd0, 2'd2});
    check("single_busy1", core_busy, 4'b0001);
    check("single_rem5",  core_remaining[7:0], 8'd5);
    check("single_ctag",  core_tag[7:0], 8'd0);
    check("single_qe1",   q_empty, 4'hF);
    for (int r = 4; r >= 1; r--) begin         // edges k+2..k+5
      step();
      check("single_rem_run", {core_busy, core_done, core_remaining[7:0]}, {4'b0001, 4'b0000, 8'(r)});
    end
    step();                                    // edge k+6: completion
    check("single_done", {core_busy, core_done, core_remaining[7:0]}, {4'b0000, 4'b0001, 8'd0});
    step();
    check("single_done_pulse_end", core_done, 4'h0);

    // ---- priority order: tags p0=1, p3=2, p1=3 ----
    core_enable = 4'h0;
    task_valid = 1'b1; task_dur = 8'd3;
    task_prio = 2'd0; step();
    task_prio = 2'd3; step();
    task_prio = 2'd1; step();
    task_valid = 1'b0;
    check("prio_qempty", q_empty, 4'b0100);
    check("prio_nodisp", core_busy, 4'h0);
    core_enable = 4'b0001;
    step();                                    // edge e
    check("prio_first",  {disp_valid, disp_core, disp_prio, core_tag[7:0]}, {1'b1, 2'd0, 2'd3, 8'd2});
    step(); step(); step();                    // edge e+3: core0 frees
    check("prio_gap", {disp_valid, core_busy}, {1'b0, 4'h0});
    step();                                    // edge e+4
    check("prio_second", {disp_valid, disp_prio, core_tag[7:0]}, {1'b1, 2'd1, 8'd3});
    step(); step(); step(); step();            // edge e+8
    check("prio_third",  {disp_valid, disp_prio, core_tag[7:0]}, {1'b1, 2'd0, 8'd1});
    wait_idle("prio_idle");

    // ---- full level: 16 pushes to p1 (tags 4..19) with cores disabled ----
    core_enable = 4'h0;
    task_valid = 1'b1; task_prio = 2'd1; task_dur = 8'd2;
    for (int i = 0; i < 16; i++) step();
    check("full_ready_p1", task_ready, 1'b0);
    check("full_tag",      task_tag, 8'd20);
    task_prio = 2'd0;
    check("full_ready_p0", task_ready, 1'b1);
    task_prio = 2'd2; task_dur = 8'd1;
    step();                                    // p2 accepted, tag 20
    check("full_p2_tag",   task_tag, 8'd21);
    check("full_qempty",   q_empty, 4'b1001);
    task_prio = 2'd1; task_dur = 8'd2;
    step();                                    // 17th p1 push refused
    check("full_stall_tag",   task_tag, 8'd21);
    check("full_stall_ready", task_ready, 1'b0);
    core_enable = 4'b0001;
    step();                                    // edge e: p2 dispatched first
    check("full_disp_p2", {disp_valid, disp_prio, task_tag}, {1'b1, 2'd2, 8'd21});
    step();                                    // edge e+1: core0 frees
    check("full_ready_still_low", task_ready, 1'b0);
    step();                                    // edge e+2: p1 pops, push still refused
    check("full_pop_p1", {disp_valid, disp_prio, task_tag}, {1'b1, 2'd1, 8'd21});
    check("full_ready_after_pop", task_ready, 1'b1);
    step();                                    // edge e+3: push accepted
    check("full_accept_late", task_tag, 8'd22);
    task_valid = 1'b0;
    core_enable = 4'hF;
    wait_idle("full_drain");

    // ---- dur 0 behaves as dur 1 (tag 22) ----
    task_valid = 1'b1; task_prio = 2'd0; task_dur = 8'd0;
    step();
    task_valid = 1'b0;
    step();
    check("dur0_busy", {core_busy, core_remaining[7:0]}, {4'b0001, 8'd1});
    step();
    check("dur0_done", {core_busy, core_done}, {4'b0000, 4'b0001});
    step();
    check("dur0_done_end", core_done, 4'h0);

    // ---- tag wrap: counter is 23; 232 accepts reach 255, one more wraps ----
    task_valid = 1'b1; task_prio = 2'd0; task_dur = 8'd1;
    for (int i = 0; i < 232; i++) step();
    check("wrap_255", task_tag, 8'd255);
    step();
    check("wrap_0", task_tag, 8'd0);
    task_valid = 1'b0;
    wait_idle("wrap_idle");

    // ---- fan-out: 6 tasks dur 10, tags 0..5 ----
    core_enable = 4'h0;
    task_valid = 1'b1; task_prio = 2'd0; task_dur = 8'd10;
    for (int i = 0; i < 6; i++) step();
    task_valid = 1'b0;
    check("fan_tag", task_tag, 8'd6);
    core_enable = 4'hF;
    for (int c = 0; c < 4; c++) begin          // edges e..e+3
      step();
      check("fan_disp", {disp_valid, disp_core}, {1'b1, 2'(c)});
    end
    for (int i = 0; i < 7; i++) step();        // edge e+10
    check("fan_e10", {disp_valid, core_busy, core_done}, {1'b0, 4'b1110, 4'b0001});
    step();                                    // edge e+11
    check("fan_e11", {disp_valid, disp_core, core_tag[7:0], core_done}, {1'b1, 2'd0, 8'd4, 4'b0010});
    step();                                    // edge e+12
    check("fan_e12", {disp_valid, disp_core, core_tag[15:8]}, {1'b1, 2'd1, 8'd5});
    step();                                    // edge e+13
    check("fan_e13", {core_busy, core_done, core_remaining[7:0]}, {4'b0011, 4'b1000, 8'd8});

    // ---- reset mid-run: cores 0,1 busy, one task queued ----
    core_enable = 4'h0;
    task_valid = 1'b1; task_prio = 2'd3; task_dur = 8'd4;
    step();
    task_valid = 1'b0;
    check("mid_pre", {core_busy, q_empty}, {4'b0011, 4'b0111});
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_busy",   core_busy, 4'h0);
    check("mid_rst_done",   core_done, 4'h0);
    check("mid_rst_rem",    core_remaining, 32'h0);
    check("mid_rst_ctag",   core_tag, 32'h0);
    check("mid_rst_disp",   {disp_valid, disp_core, disp_prio}, 5'h0);
    check("mid_rst_qempty", q_empty, 4'hF);
    check("mid_rst_tag",    task_tag, 8'h0);
    step(); step();
    check("mid_rst_hold", {core_busy, core_done}, 8'h0);
    reset_n = 1'b1;
    core_enable = 4'hF;
    for (int i = 0; i < 3; i++) begin
      step();
      check("mid_post", {disp_valid, core_busy, core_done, q_empty}, {1'b0, 4'h0, 4'h0, 4'hF});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
